// File: rtl/quad_gate_tester.sv
// quad_gate_tester: functional tester for quad 2-input gate parts
// (7400 NAND, 7402 NOR, 7408 AND, 7486 XOR). It walks the four input
// vectors {B,A} = 00,01,10,11 across all four gates. For each vector it
// waits SETTLE_CYCLES clocks, then compares every gate output with the
// expected function. The result is returned as Done plus RSLT.
//
// Optional feature: define QGT_PER_GATE_EN to add the fail_vec[3:0] output,
// which reports which gate failed. The default build reports only the
// aggregate result.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | pads released, waiting for Run high
// S_APPLY  | vector on the input pins, settle counter loaded
// S_SETTLE | counting down settle time, inputs still driven
// S_SAMPLE | outputs compared, failures accumulated, next vector chosen
// S_DONE   | pads released, Done/RSLT held until Run goes low
module quad_gate_tester #(
  parameter int SETTLE_CYCLES = 50,
  parameter int CTR_W         = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic [1:0]  gate_sel,
  input  logic [14:1] pin_in,
  output logic [14:1] pin_out,
  output logic [14:1] pin_oe,
  output logic        Done,
  output logic        RSLT,
  output logic [1:0]  state_o,
  output logic [1:0]  input_o
`ifdef QGT_PER_GATE_EN
  ,
  output logic [3:0]  fail_vec
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // Input-pin masks for the two pinout families (bit n = DIP pin n).
  localparam logic [14:1] MASK_NOR = 14'b00110110110110;
  localparam logic [14:1] MASK_STD = 14'b01101100011011;

`ifdef QGT_PER_GATE_EN
  localparam int FW = 4;
`else
  localparam int FW = 1;
`endif

  state_t            r_state;
  logic [1:0]        r_sel;
  logic [1:0]        r_vec;
  logic [CTR_W-1:0]  r_ctr;
  logic [FW-1:0]     r_fail;
  logic [14:1]       r_pin_out;
  logic [14:1]       r_pin_oe;
  logic              r_done;
  logic              r_rslt;

  logic [3:0]        w_y;
  logic              w_exp;
  logic [3:0]        w_mis;
  logic [FW-1:0]     w_mis_acc;
  logic              w_unused_pins;

  // Drive pattern for vector vec on the input pins of part sel.
  function automatic logic [14:1] f_drive(input logic [1:0] sel, input logic [1:0] vec);
    logic [14:1] d;
    d = '0;
    if (sel == 2'b01) begin
      d[2]  = vec[0]; d[3]  = vec[1];
      d[5]  = vec[0]; d[6]  = vec[1];
      d[8]  = vec[0]; d[9]  = vec[1];
      d[11] = vec[0]; d[12] = vec[1];
    end else begin
      d[1]  = vec[0]; d[2]  = vec[1];
      d[4]  = vec[0]; d[5]  = vec[1];
      d[10] = vec[0]; d[9]  = vec[1];
      d[13] = vec[0]; d[12] = vec[1];
    end
    return d;
  endfunction

  // Expected gate output for part sel with inputs a, b.
  function automatic logic f_gate(input logic [1:0] sel, input logic a, input logic b);
    logic y;
    case (sel)
      2'b00:   y = ~(a & b);
      2'b01:   y = ~(a | b);
      2'b10:   y = a & b;
      default: y = a ^ b;
    endcase
    return y;
  endfunction

  // Gather the four outputs (gate 1 in bit 0) and flag mismatches for the current vector.
  always_comb begin
    w_y = '0;
    if (r_sel == 2'b01) begin
      w_y = {pin_in[13], pin_in[10], pin_in[4], pin_in[1]};
    end else begin
      w_y = {pin_in[11], pin_in[8], pin_in[6], pin_in[3]};
    end
    w_exp = f_gate(r_sel, r_vec[0], r_vec[1]);
    w_mis = w_y ^ {4{w_exp}};
  end

`ifdef QGT_PER_GATE_EN
  assign w_mis_acc = w_mis;
  assign fail_vec  = r_fail;
`else
  assign w_mis_acc = |w_mis;
`endif

  // Pins that are only ever inputs to the part, or supplies, are never sampled.
  assign w_unused_pins = ^{pin_in[14], pin_in[12], pin_in[9], pin_in[7], pin_in[5], pin_in[2]};

  // Test sequencer; reset aborts any test and releases the pads on the same edge.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_sel     <= 2'b00;
      r_vec     <= 2'b00;
      r_ctr     <= '0;
      r_fail    <= '0;
      r_pin_out <= '0;
      r_pin_oe  <= '0;
      r_done    <= 1'b0;
      r_rslt    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Run) begin
            r_sel     <= gate_sel;
            r_fail    <= '0;
            r_vec     <= 2'b00;
            r_done    <= 1'b0;
            r_rslt    <= 1'b0;
            r_pin_oe  <= (gate_sel == 2'b01) ? MASK_NOR : MASK_STD;
            r_pin_out <= f_drive(gate_sel, 2'b00);
            r_state   <= S_APPLY;
          end
        end
        S_APPLY: begin
          r_ctr   <= CTR_W'(SETTLE_CYCLES - 1);
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_ctr == '0) begin
            r_state <= S_SAMPLE;
          end else begin
            r_ctr <= r_ctr - CTR_W'(1);
          end
        end
        S_SAMPLE: begin
          r_fail <= r_fail | w_mis_acc;
          if (r_vec != 2'b11) begin
            r_vec     <= r_vec + 2'd1;
            r_pin_out <= f_drive(r_sel, r_vec + 2'd1);
            r_state   <= S_APPLY;
          end else begin
            r_done    <= 1'b1;
            r_rslt    <= ~|(r_fail | w_mis_acc);
            r_pin_oe  <= '0;
            r_pin_out <= '0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (!Run) begin
            r_done  <= 1'b0;
            r_rslt  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Debug state encoding: APPLY and SETTLE share one code.
  always_comb begin
    state_o = 2'd0;
    case (r_state)
      S_APPLY, S_SETTLE: state_o = 2'd1;
      S_SAMPLE:          state_o = 2'd2;
      S_DONE:            state_o = 2'd3;
      default:           state_o = 2'd0;
    endcase
  end

  assign pin_out = r_pin_out;
  assign pin_oe  = r_pin_oe;
  assign Done    = r_done;
  assign RSLT    = r_rslt;
  assign input_o = r_vec;

endmodule

// File: tb/tb_quad_gate_tester.sv
// Bench for quad_gate_tester: behavioural chip models on the pads, directed tests,
// and a scoreboard queue of expected results popped when Done rises.
module tb_quad_gate_tester;

  localparam int S   = 3;
  localparam int LAT = 4 * (S + 2) + 1;

  localparam int PA_STD[4] = '{1, 4, 10, 13};
  localparam int PB_STD[4] = '{2, 5, 9, 12};
  localparam int PY_STD[4] = '{3, 6, 8, 11};
  localparam int PA_NOR[4] = '{2, 5, 8, 11};
  localparam int PB_NOR[4] = '{3, 6, 9, 12};
  localparam int PY_NOR[4] = '{1, 4, 10, 13};

  typedef struct {
    logic       rslt;
    logic [3:0] fv;
    int         lat;
  } exp_t;

  logic        Clk;
  logic        Reset;
  logic        Run;
  logic [1:0]  gate_sel;
  logic [14:1] pin_in;
  logic [14:1] pin_out;
  logic [14:1] pin_oe;
  logic        Done;
  logic        RSLT;
  logic [1:0]  state_o;
  logic [1:0]  input_o;
`ifdef QGT_PER_GATE_EN
  logic [3:0]  fail_vec;
`endif

  logic [1:0]  model_sel;
  logic        stuck8;
  exp_t        sb[$];
  int          n_vec;
  int          n_err;

  quad_gate_tester #(.SETTLE_CYCLES(S), .CTR_W(4)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Run      (Run),
    .gate_sel (gate_sel),
    .pin_in   (pin_in),
    .pin_out  (pin_out),
    .pin_oe   (pin_oe),
    .Done     (Done),
    .RSLT     (RSLT),
    .state_o  (state_o),
    .input_o  (input_o)
`ifdef QGT_PER_GATE_EN
    ,
    .fail_vec (fail_vec)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic model_fn(input logic [1:0] m, input logic a, input logic b);
    case (m)
      2'd0:    return !(a && b);
      2'd1:    return !(a || b);
      2'd2:    return a && b;
      default: return a != b;
    endcase
  endfunction

  // Chip model: pads echo driven values, gate outputs computed from the model's pinout.
  always_comb begin
    pin_in = pin_out;
    for (int g = 0; g < 4; g++) begin
      if (model_sel == 2'd1)
        pin_in[PY_NOR[g]] = model_fn(model_sel, pin_out[PA_NOR[g]], pin_out[PB_NOR[g]]);
      else
        pin_in[PY_STD[g]] = model_fn(model_sel, pin_out[PA_STD[g]], pin_out[PB_STD[g]]);
    end
    if (stuck8) pin_in[8] = 1'b0;
  end

  function automatic logic [14:1] oe_mask(input logic [1:0] sel);
    logic [14:1] m;
    m = '0;
    for (int g = 0; g < 4; g++) begin
      if (sel == 2'b01) begin
        m[PA_NOR[g]] = 1'b1;
        m[PB_NOR[g]] = 1'b1;
      end else begin
        m[PA_STD[g]] = 1'b1;
        m[PB_STD[g]] = 1'b1;
      end
    end
    return m;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full test; Run is left as the caller needs it after Done.
  task automatic run_test(input string nm, input logic [1:0] sel, input logic [1:0] model,
                          input logic stuck, input logic exp_rslt, input logic [3:0] exp_fv,
                          input bit drop_run, input bit chg_sel);
    exp_t        e;
    int          cyc;
    int          nw;
    logic [7:0]  walk;
    bit          oe_ok;
    bit          drv_ok;
    logic [14:1] m;
    logic        a;
    logic        b;
    m         = oe_mask(sel);
    model_sel = model;
    stuck8    = stuck;
    gate_sel  = sel;
    e.rslt    = exp_rslt;
    e.fv      = exp_fv;
    e.lat     = LAT;
    sb.push_back(e);
    Run    = 1'b1;
    cyc    = 0;
    nw     = 0;
    walk   = '0;
    oe_ok  = 1'b1;
    drv_ok = 1'b1;
    while (Done !== 1'b1 && cyc < 400) begin
      step();
      cyc++;
      if (cyc == 3) begin
        if (drop_run) Run = 1'b0;
        if (chg_sel) gate_sel = 2'b01;
      end
      if (pin_oe[7] || pin_oe[14]) oe_ok = 1'b0;
      if (state_o == 2'd1 || state_o == 2'd2) begin
        if (pin_oe !== m) oe_ok = 1'b0;
        a = (sel == 2'b01) ? pin_out[8] : pin_out[10];
        b = (sel == 2'b01) ? pin_out[9] : pin_out[9];
        if ({b, a} !== input_o) drv_ok = 1'b0;
      end else if (pin_oe !== '0) begin
        oe_ok = 1'b0;
      end
      if (state_o == 2'd2 && nw < 4) begin
        walk = {walk[5:0], input_o};
        nw++;
      end
    end
    e = sb.pop_front();
    chk({nm, "_latency"}, cyc, e.lat);
    chk({nm, "_done"}, Done, 1'b1);
    chk({nm, "_rslt"}, RSLT, e.rslt);
    chk({nm, "_walk"}, walk, 8'h1B);
    chk({nm, "_oe"}, oe_ok, 1'b1);
    chk({nm, "_drive"}, drv_ok, 1'b1);
`ifdef QGT_PER_GATE_EN
    chk({nm, "_fail_vec"}, fail_vec, e.fv);
`endif
  endtask

  task automatic back_to_idle();
    Run = 1'b0;
    step();
  endtask

  initial begin
    bit found;
    n_vec     = 0;
    n_err     = 0;
    Reset     = 1'b0;
    Run       = 1'b0;
    gate_sel  = 2'b00;
    model_sel = 2'd0;
    stuck8    = 1'b0;
    step();
    step();
    chk("rst_pin_out", pin_out, 14'h0);
    chk("rst_pin_oe", pin_oe, 14'h0);
    chk("rst_done", Done, 1'b0);
    chk("rst_rslt", RSLT, 1'b0);
    chk("rst_state", state_o, 2'd0);
    chk("rst_input", input_o, 2'd0);
    Reset = 1'b1;
    step();

    // NAND part, ideal model; Run then held high through DONE.
    run_test("nand", 2'b00, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    step(); step(); step();
    chk("hold_done", Done, 1'b1);
    chk("hold_state", state_o, 2'd3);
    back_to_idle();
    chk("release_done", Done, 1'b0);
    chk("release_state", state_o, 2'd0);

    // NOR part on the alternate pinout.
    run_test("nor", 2'b01, 2'd1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    back_to_idle();

    // XOR part with pin 8 (gate 3 output) stuck low.
    run_test("xor_stuck", 2'b11, 2'd3, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0);
    back_to_idle();

    // NAND chip tested as a 7408: every gate fails every vector.
    run_test("and_vs_nand", 2'b10, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0);
    step();

    // Gate select changes and Run drops mid-test; latched part rules.
    run_test("sel_change", 2'b00, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1);
    step();

    // AND part, reset asserted during SETTLE of vector 2.
    gate_sel  = 2'b10;
    model_sel = 2'd2;
    stuck8    = 1'b0;
    Run       = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (input_o == 2'd2 && state_o == 2'd1) found = 1'b1;
    end
    chk("rst_mid_reached", found, 1'b1);
    step();
    Reset = 1'b0;
    step();
    chk("rst_mid_oe", pin_oe, 14'h0);
    chk("rst_mid_out", pin_out, 14'h0);
    chk("rst_mid_done", Done, 1'b0);
    chk("rst_mid_state", state_o, 2'd0);
    chk("rst_mid_input", input_o, 2'd0);
    Reset = 1'b1;
    Run   = 1'b0;
    step();

    // AND part, ideal model, full pass after the aborted test.
    run_test("and", 2'b10, 2'd2, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    back_to_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
